// File: rtl/display_mode_ctrl.sv
// Five-view display mode controller: button edges and an optional auto timer pick the
// FND source select, with a one-cycle change pulse and a blanking window on every switch.
module display_mode_ctrl #(
   parameter int AUTO_TICKS   = 100_000_000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_sub,
   input  logic       auto_en,
   output logic [2:0] sel,
   output logic [2:0] app_led,
   output logic       sub_led,
   output logic       mode_chg,
   output logic       blank
);

   localparam int AW = (AUTO_TICKS > 2) ? $clog2(AUTO_TICKS) : 1;
   localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES + 1) : 1;
   localparam logic [AW-1:0] AUTO_LAST  = AW'(AUTO_TICKS - 1);
   localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYCLES);

   // State codes double as the mux select, so sel is simply the state register.
   typedef enum logic [2:0] {
      SW_SEC  = 3'b000,
      SW_HOUR = 3'b001,
      DIST    = 3'b010,
      TEMP    = 3'b100,
      HUMI    = 3'b101
   } state_t;

   state_t          state, state_nxt;
   logic            mode_prev, sub_prev;
   logic            mode_rise, sub_rise;
   logic            auto_active, auto_expire, view_chg;
   logic [AW-1:0]   auto_cnt;
   logic [BW-1:0]   blank_cnt;
   logic [2:0]      app_nxt;
   logic            sub_nxt;

   always_comb begin
      mode_rise   = btn_mode & ~mode_prev;
      sub_rise    = btn_sub & ~sub_prev;
      auto_active = auto_en && (state != DIST);
      auto_expire = auto_active && (auto_cnt == AUTO_LAST);
      state_nxt   = state;

      // Mode press wins; a coincident sub press or timer expiry is dropped, and a
      // sub press landing on expiry still yields only one toggle.
      if (mode_rise) begin
         case (state)
            SW_SEC, SW_HOUR: state_nxt = DIST;
            DIST:            state_nxt = TEMP;
            default:         state_nxt = SW_SEC;
         endcase
      end else if (sub_rise || auto_expire) begin
         case (state)
            SW_SEC:  state_nxt = SW_HOUR;
            SW_HOUR: state_nxt = SW_SEC;
            TEMP:    state_nxt = HUMI;
            HUMI:    state_nxt = TEMP;
            default: state_nxt = state;
         endcase
      end

      view_chg = (state_nxt != state);

      case (state_nxt)
         SW_SEC, SW_HOUR: app_nxt = 3'b001;
         DIST:            app_nxt = 3'b010;
         default:         app_nxt = 3'b100;
      endcase
      sub_nxt = (state_nxt == SW_HOUR) || (state_nxt == HUMI);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= SW_SEC;
         // Prev regs start high so a button held through reset is not seen as a press.
         mode_prev <= 1'b1;
         sub_prev  <= 1'b1;
         auto_cnt  <= '0;
         blank_cnt <= '0;
         app_led   <= 3'b001;
         sub_led   <= 1'b0;
         mode_chg  <= 1'b0;
      end else begin
         state     <= state_nxt;
         mode_prev <= btn_mode;
         sub_prev  <= btn_sub;
         app_led   <= app_nxt;
         sub_led   <= sub_nxt;
         mode_chg  <= view_chg;

         if (view_chg)
            blank_cnt <= BLANK_LOAD;
         else if (blank_cnt != '0)
            blank_cnt <= blank_cnt - BW'(1);

         // Expiry always changes the view, so it also lands in the clear branch.
         if (view_chg || !auto_active)
            auto_cnt <= '0;
         else
            auto_cnt <= auto_cnt + AW'(1);
      end
   end

   assign sel   = state;
   assign blank = (blank_cnt != '0);

endmodule

// File: tb/tb_display_mode_ctrl.sv
// Bench for display_mode_ctrl: directed vector table, hand sequences for timing corners,
// and random stimulus scored against an application/sub-view reference model.
module tb_display_mode_ctrl;

   localparam int AUTO_TICKS   = 10;
   localparam int BLANK_CYCLES = 4;

   logic       clk = 1'b0;
   logic       reset, btn_mode, btn_sub, auto_en;
   logic [2:0] sel, app_led;
   logic       sub_led, mode_chg, blank;

   int checks = 0;
   int errors = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   display_mode_ctrl #(
      .AUTO_TICKS  (AUTO_TICKS),
      .BLANK_CYCLES(BLANK_CYCLES)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .btn_mode(btn_mode),
      .btn_sub (btn_sub),
      .auto_en (auto_en),
      .sel     (sel),
      .app_led (app_led),
      .sub_led (sub_led),
      .mode_chg(mode_chg),
      .blank   (blank)
   );

   // ---------------- reference model ----------------
   // View = (application index 0..2, sub-view bit); sel comes from a lookup table.
   logic [2:0] sel_of [3][2] = '{'{3'd0, 3'd1}, '{3'd2, 3'd2}, '{3'd4, 3'd5}};
   int   m_app, m_cnt, m_blank;
   bit   m_sub, m_chg, m_pm, m_ps;
   logic [8:0] exp_q[$];

   task automatic model_step(input logic r, bm, bs, ae);
      int old_app;
      bit old_sub, mrise, srise, expire, changed;
      if (r) begin
         m_app = 0; m_sub = 0; m_cnt = 0; m_blank = 0; m_chg = 0; m_pm = 1; m_ps = 1;
      end else begin
         mrise   = bm && !m_pm;
         srise   = bs && !m_ps;
         old_app = m_app;
         old_sub = m_sub;
         expire  = ae && (m_app != 1) && (m_cnt == AUTO_TICKS - 1);
         if (mrise) begin
            m_app = (m_app + 1) % 3;
            m_sub = 0;
         end else if ((srise || expire) && m_app != 1) begin
            m_sub = !m_sub;
         end
         changed = (m_app != old_app) || (m_sub != old_sub);
         m_chg   = changed;
         if (changed) m_blank = BLANK_CYCLES;
         else if (m_blank > 0) m_blank--;
         if (changed || !ae || old_app == 1) m_cnt = 0;
         else m_cnt++;
         m_pm = bm;
         m_ps = bs;
      end
      exp_q.push_back({sel_of[m_app][m_sub], 3'(3'b001 << m_app), logic'(m_sub),
                       logic'(m_chg), logic'(m_blank > 0)});
   endtask

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- driver ----------------
   task automatic apply(input logic r, bm, bs, ae);
      logic [8:0] exp;
      reset    = r;
      btn_mode = bm;
      btn_sub  = bs;
      auto_en  = ae;
      @(posedge clk);
      model_step(r, bm, bs, ae);
      #1;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL sb_empty: no expected entry at t=%0t", $time);
      end else begin
         exp = exp_q.pop_front();
         check("sb", {sel, app_led, sub_led, mode_chg, blank}, exp);
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic       rst, bm, bs, ae;
      logic [2:0] sel, app;
      logic       sub, chg, blk;
   } vec_t;
   vec_t vecs[$];

   task automatic add_vec(input logic rst, bm, bs, ae, input logic [2:0] s, a,
                          input logic sb, c, b);
      vec_t v;
      v.rst = rst; v.bm = bm; v.bs = bs; v.ae = ae;
      v.sel = s; v.app = a; v.sub = sb; v.chg = c; v.blk = b;
      vecs.push_back(v);
   endtask

   // One-cycle press then release; blank covers the press cycle plus three more.
   task automatic add_press(input logic bm, bs, input logic [2:0] s, a, input logic sb);
      add_vec(0, bm, bs, 0, s, a, sb, 1, 1);
      repeat (3) add_vec(0, 0, 0, 0, s, a, sb, 0, 1);
      add_vec(0, 0, 0, 0, s, a, sb, 0, 0);
   endtask

   initial begin
      logic [2:0] prev_sel;
      int         n_chg;
      int         tog[$];
      int         exp_tog[3] = '{10, 20, 30};
      logic       r, bm, bs, ae;
      int         prob;

      reset = 1'b1; btn_mode = 1'b0; btn_sub = 1'b0; auto_en = 1'b0;

      // reset, then four mode presses
      add_vec(1, 0, 0, 0, 3'd0, 3'b001, 0, 0, 0);
      add_vec(0, 0, 0, 0, 3'd0, 3'b001, 0, 0, 0);
      add_press(1, 0, 3'd2, 3'b010, 0);
      add_press(1, 0, 3'd4, 3'b100, 0);
      add_press(1, 0, 3'd0, 3'b001, 0);
      add_press(1, 0, 3'd2, 3'b010, 0);
      // sub press in DIST is ignored
      add_vec(0, 0, 1, 0, 3'd2, 3'b010, 0, 0, 0);
      add_vec(0, 0, 0, 0, 3'd2, 3'b010, 0, 0, 0);
      // back to SW_SEC, sub toggles twice
      add_press(1, 0, 3'd4, 3'b100, 0);
      add_press(1, 0, 3'd0, 3'b001, 0);
      add_press(0, 1, 3'd1, 3'b001, 1);
      add_press(0, 1, 3'd0, 3'b001, 0);
      // to HUMI, then simultaneous rises
      add_press(1, 0, 3'd2, 3'b010, 0);
      add_press(1, 0, 3'd4, 3'b100, 0);
      add_press(0, 1, 3'd5, 3'b100, 1);
      add_press(1, 1, 3'd0, 3'b001, 0);
      // second change at cycle 2 of a blank window restarts it
      add_vec(0, 0, 1, 0, 3'd1, 3'b001, 1, 1, 1);
      add_vec(0, 0, 0, 0, 3'd1, 3'b001, 1, 0, 1);
      add_press(0, 1, 3'd0, 3'b001, 0);
      // reset mid-blank in HUMI
      add_press(1, 0, 3'd2, 3'b010, 0);
      add_press(1, 0, 3'd4, 3'b100, 0);
      add_vec(0, 0, 1, 0, 3'd5, 3'b100, 1, 1, 1);
      add_vec(0, 0, 0, 0, 3'd5, 3'b100, 1, 0, 1);
      add_vec(1, 0, 0, 0, 3'd0, 3'b001, 0, 0, 0);
      add_vec(0, 0, 0, 0, 3'd0, 3'b001, 0, 0, 0);
      // mode held across reset deassert: no press until release and re-press
      add_vec(1, 1, 0, 0, 3'd0, 3'b001, 0, 0, 0);
      repeat (3) add_vec(0, 1, 0, 0, 3'd0, 3'b001, 0, 0, 0);
      add_vec(0, 0, 0, 0, 3'd0, 3'b001, 0, 0, 0);
      add_press(1, 0, 3'd2, 3'b010, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i].rst, vecs[i].bm, vecs[i].bs, vecs[i].ae);
         check($sformatf("vec%0d_sel", i),     sel,      vecs[i].sel);
         check($sformatf("vec%0d_app_led", i), app_led,  vecs[i].app);
         check($sformatf("vec%0d_sub_led", i), sub_led,  vecs[i].sub);
         check($sformatf("vec%0d_mode_chg", i), mode_chg, vecs[i].chg);
         check($sformatf("vec%0d_blank", i),   blank,    vecs[i].blk);
      end

      // held mode button from TEMP: exactly one transition, to SW_SEC
      apply(0, 1, 0, 0);
      apply(0, 0, 0, 0);
      check("hold_pre_sel", sel, 3'd4);
      n_chg = 0;
      for (int i = 0; i < 50; i++) begin
         prev_sel = sel;
         apply(0, 1, 0, 0);
         if (sel != prev_sel) n_chg++;
      end
      check("hold_nchg", n_chg, 1);
      check("hold_sel", sel, 3'd0);
      apply(0, 0, 0, 0);

      // auto toggle in TEMP: toggles on cycles 10, 20, 30
      apply(0, 1, 0, 0); apply(0, 0, 0, 0);
      apply(0, 1, 0, 0); apply(0, 0, 0, 0);
      check("auto_pre_sel", sel, 3'd4);
      for (int i = 1; i <= 35; i++) begin
         prev_sel = sel;
         apply(0, 0, 0, 1);
         if (sel != prev_sel) tog.push_back(i);
      end
      check("auto_ntog", tog.size(), 3);
      for (int k = 0; k < 3 && k < tog.size(); k++)
         check($sformatf("auto_tog%0d", k), tog[k], exp_tog[k]);

      // auto enabled in DIST: nothing moves
      apply(0, 1, 0, 0); apply(0, 0, 0, 0);
      apply(0, 1, 0, 0); apply(0, 0, 0, 0);
      check("dist_pre_sel", sel, 3'd2);
      n_chg = 0;
      for (int i = 0; i < 30; i++) begin
         prev_sel = sel;
         apply(0, 0, 0, 1);
         if (sel != prev_sel) n_chg++;
      end
      check("dist_auto_nchg", n_chg, 0);
      check("dist_auto_sel", sel, 3'd2);

      // random stimulus against the model
      apply(1, 0, 0, 0);
      bm = 0; bs = 0; ae = 0;
      for (int i = 0; i < 1500; i++) begin
         prob = (i < 750) ? 5 : 19;
         if ($urandom_range(0, prob) == 0) bm = !bm;
         if ($urandom_range(0, prob) == 0) bs = !bs;
         if ($urandom_range(0, 29) == 0)   ae = !ae;
         r = ($urandom_range(0, 199) == 0);
         apply(r, bm, bs, ae);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/display_mode_ctrl.md
# display_mode_ctrl

Mode controller that generates the 3-bit display-source select consumed by the 5-to-1 FND data mux. It turns debounced button levels into a five-view state machine covering stopwatch seconds, stopwatch hours, distance sensor, temperature and humidity. It also offers optional timed auto-toggling between sub-views, plus a blanking window on every view change so the FND never shows a half-switched value. Sits between the button debouncers and the display mux / FND controller.

## Interface

Parameters:
- AUTO_TICKS, 100_000_000, clock cycles per auto-toggle period (1 s at 100 MHz); ≥2
- BLANK_CYCLES, 1000, length of the blank pulse after a view change; ≥1

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- btn_mode  input  1  debounced level, mode button; rising edge selects next application
- btn_sub  input  1  debounced level, sub button; rising edge toggles sub-view within the application
- auto_en  input  1  level; 1 enables timed sub-view toggling
- sel  output  3  display source select: 000 SW_SEC, 001 SW_HOUR, 010 DIST, 100 TEMP, 101 HUMI
- app_led  output  3  one-hot application indicator: 001 stopwatch, 010 distance, 100 temp/humidity
- sub_led  output  1  1 when in SW_HOUR or HUMI, else 0
- mode_chg  output  1  one-cycle pulse on every view change
- blank  output  1  high for BLANK_CYCLES cycles after each view change

## Operation

- States: SW_SEC, SW_HOUR, DIST, TEMP, HUMI. sel is a registered output and equals the state code. Codes 011, 110 and 111 are never driven.
- Edge detect: the block keeps registers mode_prev and sub_prev. A rise is btn & ~prev, evaluated each cycle.
- btn_mode rise:
  - SW_SEC or SW_HOUR → DIST
  - DIST → TEMP
  - TEMP or HUMI → SW_SEC
  - Entering an application always lands on its first sub-view.
- btn_sub rise:
  - SW_SEC ↔ SW_HOUR
  - TEMP ↔ HUMI
  - In DIST: no state change and no mode_chg.
- Simultaneous rises: btn_mode wins and the btn_sub rise is discarded; it is not queued.
- Auto-toggle: a counter runs only while auto_en=1 and the state is not DIST.
  - When the count reaches AUTO_TICKS-1, the sub-view toggles exactly as for a btn_sub rise, and the counter returns to 0.
  - The counter clears on any view change (manual or auto), on auto_en=0, and while in DIST.
  - A btn_sub rise in the same cycle as auto expiry produces a single toggle, not two.
- View change: any cycle in which the next state differs from the current state.
  - mode_chg goes high for exactly one cycle.
  - The blank counter loads BLANK_CYCLES.
  - blank stays high while the counter is nonzero.
  - A new change during blank restarts the full window.
- app_led and sub_led are registered decodes of the next state, so they update together with sel.

## Timing

- Reset values: state SW_SEC, sel=000, app_led=001, sub_led=0, mode_chg=0, blank=0, both counters 0.
- mode_prev and sub_prev reset to 1. A button held through reset is not a press; it must be released and pressed again.
- Latency:
  - A btn level first sampled high at edge k, with prev=0, updates sel, app_led and sub_led at edge k.
  - mode_chg is high during the cycle following edge k.
  - blank is high for cycles k..k+BLANK_CYCLES-1.
- Held buttons cause no repeat: one rise gives one transition.
- Reset mid-blank or mid-auto-count returns everything to the reset values on that edge. Reset has priority over every input.
- Auto-toggle period: with auto_en held high and no other activity, toggles occur every AUTO_TICKS cycles exactly.

## Test plan

Bench uses AUTO_TICKS=10 and BLANK_CYCLES=4.

- Reset, then four single-cycle-rise btn_mode presses → sel 000→010→100→000→010; app_led 001→010→100→001→010; one mode_chg pulse per press; blank high 4 cycles after each press.
- In SW_SEC, press btn_sub twice → sel 000→001→000, sub_led 0→1→0. In DIST, press btn_sub → sel stays 010, no mode_chg, blank stays 0.
- Hold btn_mode high for 50 cycles from TEMP → exactly one transition, to 000. btn_mode and btn_sub rising in the same cycle from HUMI → sel=000, sub_led=0.
- auto_en=1 in TEMP for 35 cycles → sel toggles 100/101 at cycles 10, 20 and 30. In DIST with auto_en=1 for 30 cycles → sel stays 010.
- Press btn_sub at cycle 2 of a blank window → blank extends to 4 cycles after the second change; 2 mode_chg pulses total.
- btn_mode held high across reset deassert → no transition until release and re-press. Reset asserted mid-blank in HUMI → next cycle sel=000, app_led=001, blank=0, mode_chg=0.
